netwalk_encoder: RTL and testbench
==================================

# netwalk_encoder

One-hot to binary encoder with a registered output for the NetWalk data plane. It converts a 2^N-bit one-hot select vector into its N-bit index and presents the result one clock later. Typical use is turning match-line or request vectors from lookup and arbitration stages into table addresses. Inputs that are not strictly one-hot resolve deterministically to the lowest set bit.

## Interface
- ENCODER_OUT_WIDTH, default 6: width N of the binary output.
- ENCODER_IN_WIDTH, default 1<<ENCODER_OUT_WIDTH: width of the one-hot input. Derived from N; not overridden independently.
- clk  input  1: single clock; all state updates on the rising edge.
- reset  input  1: asynchronous, active-high reset.
- encoder_in  input  ENCODER_IN_WIDTH: one-hot input vector.
- encoder_out  output  ENCODER_OUT_WIDTH: registered index of the selected bit.
- encoder_valid  output  1: registered; high when the sampled encoder_in had at least one bit set.
- encoder_enable  input  1: present only with NETWALK_ENCODER_ENABLE_EN (see Configuration).

## Operation
- Combinational stage:
  - Priority-encode encoder_in so that the lowest-index set bit wins.
  - Strictly one-hot input i produces index i.
  - Multi-hot input produces the minimum set index (for example, 0x...0A gives 1).
  - All-zero input produces index 0 with valid 0.
- Register stage: on each rising clk, encoder_out and encoder_valid capture the combinational result.
- No internal state beyond the two output registers.
- Width rules:
  - The output covers indices 0..ENCODER_IN_WIDTH-1 exactly.
  - There are no unused codes and no overflow.

## Timing
- Latency: exactly 1 cycle.
  - encoder_in sampled at edge k appears on encoder_out/encoder_valid after edge k.
  - Throughput is one conversion per cycle.
- Reset values: encoder_out = 0, encoder_valid = 0.
  - reset takes effect immediately, without waiting for clk.
  - Outputs hold these values while reset is high.
  - The first capture happens at the first rising edge after reset deasserts.
- Reset mid-stream: any in-flight result is discarded; there is no recovery cycle.
- Input changes between edges have no effect on the outputs until the next edge.
- encoder_out = 0 with encoder_valid = 0 means "no bit set". encoder_out = 0 with encoder_valid = 1 means "bit 0 set".

## Configuration
- Macro: NETWALK_ENCODER_ENABLE_EN.
- When defined:
  - The encoder_enable input port exists.
  - Output registers load only on edges where encoder_enable = 1.
  - While encoder_enable = 0, encoder_out and encoder_valid hold their previous values.
  - Reset still overrides encoder_enable.
- When undefined:
  - The port is absent.
  - The registers load on every edge, which is equivalent to encoder_enable tied to 1.

## Structure
- Shared package netwalk_pkg holds:
  - the default NETWALK_ENC_OUT_WIDTH = 6;
  - the derived input-width constant;
  - a typedef for the index type.
- One natural sub-module: netwalk_prio_enc.
  - Purely combinational, parameterised lowest-index-first priority encoder.
  - Produces an index and an any-set flag.
  - Built as a log2 tree of pairwise merges so timing scales with N, not 2^N.
- The top level wraps netwalk_prio_enc with the output registers and the optional enable.

## Test plan
- Reset and basics (N=6): hold reset high, apply encoder_in = 1<<5 → outputs stay 0/0. Deassert reset; next edge → out 5, valid 1.
- One-hot sweep, applied on consecutive cycles (each result appears one cycle after its input):
  - bit0 → 0
  - bit63 → 63
  - bit3 → 3
  - bit19 → 19
  - bit42 → 42
  - bit62 → 62
- Zero input: encoder_in = 0 → out 0, valid 0. Then bit0 → out 0, valid 1.
- Multi-hot priority:
  - bits {63, 42, 3} → 3
  - all-ones → 0
- Asynchronous reset: assert reset mid-cycle while out = 42 → out 0, valid 0 before the next edge. The first edge after release loads the current input.
- With NETWALK_ENCODER_ENABLE_EN:
  - Load bit19 with enable = 1 → out 19.
  - Drop enable and drive bit62 → out stays 19.
  - Raise enable → out 62 one edge later.

Source files
------------

// File: rtl/netwalk_pkg.sv
// Shared constants and types for the NetWalk one-hot encoder.
// The default output width is 6, which gives a 64-bit one-hot input.
package netwalk_pkg;

   localparam int NETWALK_ENC_OUT_WIDTH = 6;
   localparam int NETWALK_ENC_IN_WIDTH  = 1 << NETWALK_ENC_OUT_WIDTH;

   typedef logic [NETWALK_ENC_OUT_WIDTH-1:0] netwalk_enc_idx_t;

endpackage : netwalk_pkg

// File: rtl/netwalk_prio_enc.sv
// Combinational lowest-index-first priority encoder.
// Built as a log2 tree of pairwise merges. Level 0 has one node per input
// bit. Each node at level l covers 2^l input bits and knows two things: the
// offset of its lowest set bit inside that span, and whether any bit is set.
// When two children merge, the low child wins if it has any bit set.
// Otherwise the high child's offset is used, with bit (l-1) added.
// An all-zero span always reports offset 0, so an all-zero input gives idx 0.
module netwalk_prio_enc
   import netwalk_pkg::*;
#(
   parameter int OUT_W = NETWALK_ENC_OUT_WIDTH,
   parameter int IN_W  = 1 << OUT_W
) (
   input  logic [IN_W-1:0]  in_i,
   output logic [OUT_W-1:0] idx_o,
   output logic             any_o
);

   for (genvar l = 0; l <= OUT_W; l++) begin : g_lvl
      localparam int NODES = 1 << (OUT_W - l);

      logic [OUT_W-1:0] idx [NODES];
      logic [NODES-1:0] any;

      if (l == 0) begin : g_leaf
         for (genvar j = 0; j < NODES; j++) begin : g_node
            assign any[j] = in_i[j];
            assign idx[j] = '0;
         end
      end else begin : g_merge
         for (genvar j = 0; j < NODES; j++) begin : g_node
            logic [OUT_W-1:0] hi_idx;

            // Offset of the high child, moved into this node's span.
            // Bit (l-1) is only set when the high child has a bit set.
            always_comb begin
               hi_idx      = g_lvl[l-1].idx[2*j+1];
               hi_idx[l-1] = g_lvl[l-1].any[2*j+1];
            end

            assign any[j] = g_lvl[l-1].any[2*j] | g_lvl[l-1].any[2*j+1];
            assign idx[j] = g_lvl[l-1].any[2*j] ? g_lvl[l-1].idx[2*j] : hi_idx;
         end
      end
   end

   assign idx_o = g_lvl[OUT_W].idx[0];
   assign any_o = g_lvl[OUT_W].any[0];

endmodule : netwalk_prio_enc

// File: rtl/netwalk_encoder.sv
// One-hot to binary encoder with registered index and valid outputs.
// Latency is one cycle. If more than one bit is set, the lowest set bit wins.
// Optional macro NETWALK_ENCODER_ENABLE_EN adds the encoder_enable load-enable
// input. Without it, the output registers load on every rising edge.
module netwalk_encoder
   import netwalk_pkg::*;
#(
   parameter int ENCODER_OUT_WIDTH = NETWALK_ENC_OUT_WIDTH,
   parameter int ENCODER_IN_WIDTH  = 1 << ENCODER_OUT_WIDTH
) (
   input  logic                         clk,
   input  logic                         reset,
`ifdef NETWALK_ENCODER_ENABLE_EN
   input  logic                         encoder_enable,
`endif
   input  logic [ENCODER_IN_WIDTH-1:0]  encoder_in,
   output logic [ENCODER_OUT_WIDTH-1:0] encoder_out,
   output logic                         encoder_valid
);

   logic [ENCODER_OUT_WIDTH-1:0] enc_idx;
   logic                         enc_any;

   logic [ENCODER_OUT_WIDTH-1:0] out_q, out_d;
   logic                         valid_q, valid_d;

   netwalk_prio_enc #(
      .OUT_W (ENCODER_OUT_WIDTH),
      .IN_W  (ENCODER_IN_WIDTH)
   ) u_prio_enc (
      .in_i  (encoder_in),
      .idx_o (enc_idx),
      .any_o (enc_any)
   );

   // Next state for the output registers: load the new result, or hold it
   // while the load enable is low.
   always_comb begin
      // NOTE: default to the current value first, so every path assigns
      // out_d and valid_d and no latch is inferred.
      out_d   = out_q;
      valid_d = valid_q;
`ifdef NETWALK_ENCODER_ENABLE_EN
      if (encoder_enable) begin
         out_d   = enc_idx;
         valid_d = enc_any;
      end
`else
      out_d   = enc_idx;
      valid_d = enc_any;
`endif
   end

   // Output registers. Reset is asynchronous and clears both outputs at once.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: non-blocking assignments keep every register sampling
      // pre-edge values, so simulation matches the synthesized flops.
      if (reset) begin
         out_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         out_q   <= out_d;
         valid_q <= valid_d;
      end
   end

   assign encoder_out   = out_q;
   assign encoder_valid = valid_q;

endmodule : netwalk_encoder

// File: tb/tb_netwalk_encoder.sv
// Self-checking bench for netwalk_encoder. It uses directed vectors with
// hand-computed expectations. A behavioural model, checked on every falling
// edge, finds the lowest set bit with a plain search loop.
// The NETWALK_ENCODER_ENABLE_EN section runs only when that macro is defined.
module tb_netwalk_encoder;
   import netwalk_pkg::*;

   localparam int OW = NETWALK_ENC_OUT_WIDTH;
   localparam int IW = NETWALK_ENC_IN_WIDTH;

   logic                clk;
   logic                reset;
   logic                encoder_enable;
   logic [IW-1:0]       encoder_in;
   netwalk_enc_idx_t    encoder_out;
   logic                encoder_valid;

   int checks = 0;
   int errors = 0;

   netwalk_encoder dut (
      .clk            (clk),
      .reset          (reset),
`ifdef NETWALK_ENCODER_ENABLE_EN
      .encoder_enable (encoder_enable),
`endif
      .encoder_in     (encoder_in),
      .encoder_out    (encoder_out),
      .encoder_valid  (encoder_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: index of the lowest set bit, or -1 when no bit is set.
   function automatic int lowest_set(input logic [IW-1:0] v);
      for (int i = 0; i < IW; i++)
         if (v[i]) return i;
      return -1;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model of what the outputs must show after each edge.
   netwalk_enc_idx_t m_out;
   logic             m_valid;
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_out   <= '0;
         m_valid <= 1'b0;
      end else begin
`ifdef NETWALK_ENCODER_ENABLE_EN
         if (encoder_enable) begin
`else
         begin
`endif
            m_out   <= (lowest_set(encoder_in) < 0) ? '0 : OW'(lowest_set(encoder_in));
            m_valid <= (lowest_set(encoder_in) >= 0);
         end
      end
   end

   // Compare the DUT with the model on every falling edge.
   always @(negedge clk) begin
      check("model_out", 64'(encoder_out), 64'(m_out));
      check("model_valid", 64'(encoder_valid), 64'(m_valid));
   end

   // Drive one input. Sample the result #1 after the next rising edge.
   task automatic drive_check(input string name, input logic [IW-1:0] vec,
                              input int exp_out, input logic exp_valid);
      encoder_in = vec;
      @(posedge clk);
      #1;
      check({name, "_out"}, 64'(encoder_out), 64'(exp_out));
      check({name, "_valid"}, 64'(encoder_valid), 64'(exp_valid));
   endtask

   function automatic logic [IW-1:0] bit_vec(input int k);
      logic [IW-1:0] v;
      v = '0;
      v[k] = 1'b1;
      return v;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "timeout");
   end

   initial begin
      int sweep [6] = '{0, 63, 3, 19, 42, 62};

      reset          = 1'b1;
      encoder_enable = 1'b1;
      encoder_in     = bit_vec(5);

      // Reset held high: the input must not reach the outputs.
      repeat (2) @(posedge clk);
      #1;
      check("rst_hold_out", 64'(encoder_out), 64'd0);
      check("rst_hold_valid", 64'(encoder_valid), 64'd0);

      // Release reset. The next edge loads bit 5.
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("first_out", 64'(encoder_out), 64'd5);
      check("first_valid", 64'(encoder_valid), 64'd1);

      // One-hot sweep on consecutive cycles.
      foreach (sweep[i])
         drive_check($sformatf("sweep%0d", sweep[i]), bit_vec(sweep[i]), sweep[i], 1'b1);

      // Zero input, then bit 0, to tell "none" from "bit 0".
      drive_check("zero", '0, 0, 1'b0);
      drive_check("bit0", bit_vec(0), 0, 1'b1);

      // Multi-hot inputs resolve to the lowest set bit.
      drive_check("multi", bit_vec(63) | bit_vec(42) | bit_vec(3), 3, 1'b1);
      drive_check("ones", '1, 0, 1'b1);
      drive_check("hex0a", 64'h0A, 1, 1'b1);

      // Input changes between edges: only the value at the edge counts.
      encoder_in = bit_vec(7);
      #2;
      drive_check("late_change", bit_vec(11), 11, 1'b1);

      // Asynchronous reset mid-cycle while out = 42.
      drive_check("pre_rst", bit_vec(42), 42, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_out", 64'(encoder_out), 64'd0);
      check("async_rst_valid", 64'(encoder_valid), 64'd0);
      encoder_in = bit_vec(19);
      @(posedge clk);
      #1;
      check("rst_edge_out", 64'(encoder_out), 64'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_out", 64'(encoder_out), 64'd19);
      check("post_rst_valid", 64'(encoder_valid), 64'd1);

`ifdef NETWALK_ENCODER_ENABLE_EN
      // Load enable: hold while low, load again once it rises.
      encoder_enable = 1'b1;
      drive_check("en_load", bit_vec(19), 19, 1'b1);
      encoder_enable = 1'b0;
      drive_check("en_hold", bit_vec(62), 19, 1'b1);
      drive_check("en_hold2", '0, 19, 1'b1);
      encoder_enable = 1'b1;
      drive_check("en_resume", bit_vec(62), 62, 1'b1);
      // Reset still clears the outputs while the enable is low.
      encoder_enable = 1'b0;
      reset = 1'b1;
      #1;
      check("en_rst_out", 64'(encoder_out), 64'd0);
      reset = 1'b0;
      encoder_enable = 1'b1;
`endif

      // Run a few more cycles so the model comparison covers the tail.
      drive_check("tail", bit_vec(33), 33, 1'b1);
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_netwalk_encoder
